// File: rtl/sysbus_arbiter.sv
// Two-requester Sysbus read arbiter: grants whole transactions (request + BEATS beats) to IF or DM.
// Define SYSBUS_ARB_RR_EN for round-robin tie-breaking; otherwise DM wins ties.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      if_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] if_req,
  input  logic [BUS_TAG_WIDTH-1:0]  if_reqtag,
  output logic                      if_reqack,
  output logic                      if_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] if_resp,
  output logic [BUS_TAG_WIDTH-1:0]  if_resptag,
  input  logic                      if_respack,
  input  logic                      dm_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] dm_req,
  input  logic [BUS_TAG_WIDTH-1:0]  dm_reqtag,
  output logic                      dm_reqack,
  output logic                      dm_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dm_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dm_resptag,
  input  logic                      dm_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int CW = $clog2(BEATS) + 1;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_q, last_d;
  logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic tie_dm, win_dm, own_respack, beat;

`ifdef SYSBUS_ARB_RR_EN
  assign tie_dm = (last_q == OWN_IF);
`else
  assign tie_dm = 1'b1;
`endif

  assign win_dm      = dm_reqcyc && (!if_reqcyc || tie_dm);
  assign own_respack = (owner_q == OWN_DM) ? dm_respack : if_respack;
  assign beat        = (state_q == RESP) && bus_respcyc && own_respack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_DM;
      addr_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (if_reqcyc || dm_reqcyc) begin
        owner_d = win_dm ? OWN_DM : OWN_IF;
        addr_d  = win_dm ? dm_req : if_req;
        tag_d   = win_dm ? dm_reqtag : if_reqtag;
        cnt_d   = '0;
        state_d = REQ;
      end
      REQ: if (bus_reqack) state_d = RESP;
      RESP: if (beat) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BEATS - 1)) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode purely from state/owner so an async reset zeroes them at once.
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    if_reqack   = 1'b0;
    if_respcyc  = 1'b0;
    if_resp     = '0;
    if_resptag  = '0;
    dm_reqack   = 1'b0;
    dm_respcyc  = 1'b0;
    dm_resp     = '0;
    dm_resptag  = '0;
    if (state_q == REQ) begin
      bus_reqcyc = 1'b1;
      bus_req    = addr_q;
      bus_reqtag = tag_q;
      if (owner_q == OWN_DM) dm_reqack = bus_reqack;
      else                   if_reqack = bus_reqack;
    end
    if (state_q == RESP) begin
      bus_respack = own_respack;
      if (owner_q == OWN_DM) begin
        dm_respcyc = bus_respcyc;
        dm_resp    = bus_resp;
        dm_resptag = bus_resptag;
      end else begin
        if_respcyc = bus_respcyc;
        if_resp    = bus_resp;
        if_resptag = bus_resptag;
      end
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: cycle table for one IF transaction plus hand sequences.
module tb_sysbus_arbiter;
  localparam logic [3:0]  SYSBUS_MEMORY = 4'b0001;
  localparam logic [12:0] TAG_IF = {1'b1, SYSBUS_MEMORY, 8'b0};
  localparam logic [12:0] TAG_DM = 13'h0a55;

  logic clk = 0, reset = 0;
  logic if_reqcyc = 0, dm_reqcyc = 0, if_respack = 0, dm_respack = 0;
  logic [63:0] if_req = 0, dm_req = 0;
  logic [12:0] if_reqtag = 0, dm_reqtag = 0;
  logic if_reqack, dm_reqack, if_respcyc, dm_respcyc;
  logic [63:0] if_resp, dm_resp;
  logic [12:0] if_resptag, dm_resptag;
  logic bus_reqcyc, bus_respack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic bus_reqack = 0, bus_respcyc = 0;
  logic [63:0] bus_resp = 0;
  logic [12:0] bus_resptag = 0;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  sysbus_arbiter dut (
    .clk(clk), .reset(reset),
    .if_reqcyc(if_reqcyc), .if_req(if_req), .if_reqtag(if_reqtag), .if_reqack(if_reqack),
    .if_respcyc(if_respcyc), .if_resp(if_resp), .if_resptag(if_resptag), .if_respack(if_respack),
    .dm_reqcyc(dm_reqcyc), .dm_req(dm_req), .dm_reqtag(dm_reqtag), .dm_reqack(dm_reqack),
    .dm_respcyc(dm_respcyc), .dm_resp(dm_resp), .dm_resptag(dm_resptag), .dm_respack(dm_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  typedef struct {
    logic ic, ba, rc;
    logic [63:0] rd;
    logic e_br;
    logic [63:0] e_ba;
    logic e_ia, e_irc;
    logic [63:0] e_ir;
    logic e_bra;
  } vec_t;

  function automatic vec_t mk(logic ic, logic ba, logic rc, logic [63:0] rd, logic e_br,
                              logic [63:0] e_ba, logic e_ia, logic e_irc, logic [63:0] e_ir,
                              logic e_bra);
    vec_t v;
    v.ic = ic; v.ba = ba; v.rc = rc; v.rd = rd; v.e_br = e_br; v.e_ba = e_ba;
    v.e_ia = e_ia; v.e_irc = e_irc; v.e_ir = e_ir; v.e_bra = e_bra;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic dm, input logic v);
    if (dm) dm_reqcyc = v; else if_reqcyc = v;
  endtask

  // Plays the Sysbus side of one transaction and checks the owner/non-owner views.
  task automatic serve(input logic dm, input logic [63:0] ea, input logic [12:0] et,
                       input int ack_dly, input logic drop_early, input logic hold,
                       input int stall_beat, input int dm_at_beat);
    int n = 0;
    while (!bus_reqcyc && n < 20) begin tick(); n++; end
    if (!bus_reqcyc) begin
      chk("grant_timeout", 64'(bus_reqcyc), 64'd1);
      return;
    end
    for (int d = 0; d < ack_dly; d++) begin
      if (drop_early && d == 2) set_req(dm, 1'b0);
      #1;
      chk("req_addr_hold", bus_req, ea);
      chk("req_tag_hold", 64'(bus_reqtag), 64'(et));
      chk("reqack_early", 64'(dm ? dm_reqack : if_reqack), 64'd0);
      tick();
    end
    bus_reqack = 1; #1;
    chk("req_addr", bus_req, ea);
    chk("own_reqack", 64'(dm ? dm_reqack : if_reqack), 64'd1);
    chk("oth_reqack", 64'(dm ? if_reqack : dm_reqack), 64'd0);
    tick();
    bus_reqack = 0;
    if (!hold) set_req(dm, 1'b0);
    if_respack = 1; dm_respack = 1;
    for (int b = 1; b <= 8; b++) begin
      if (b == dm_at_beat) begin
        dm_reqcyc = 1; dm_req = 64'h5000; dm_reqtag = TAG_DM;
      end
      bus_respcyc = 1; bus_resp = 64'(b * 'h11); bus_resptag = 13'(b + 'h40);
      if (b == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          set_req(1'b0, if_reqcyc);
          if (dm) dm_respack = 0; else if_respack = 0;
          #1;
          chk("stall_respack", 64'(bus_respack), 64'd0);
          chk("stall_respcyc", 64'(dm ? dm_respcyc : if_respcyc), 64'd1);
          tick();
        end
        if (dm) dm_respack = 1; else if_respack = 1;
      end
      #1;
      chk("own_respcyc", 64'(dm ? dm_respcyc : if_respcyc), 64'd1);
      chk("own_resp", dm ? dm_resp : if_resp, 64'(b * 'h11));
      chk("own_resptag", 64'(dm ? dm_resptag : if_resptag), 64'(b + 'h40));
      chk("oth_respcyc", 64'(dm ? if_respcyc : dm_respcyc), 64'd0);
      chk("oth_resp", dm ? if_resp : dm_resp, 64'd0);
      chk("bus_respack", 64'(bus_respack), 64'd1);
      tick();
    end
    // Beat still offered: an arbiter left in RESP would forward it.
    bus_resp = 64'hdead; #1;
    chk("idle_respcyc", 64'(dm ? dm_respcyc : if_respcyc), 64'd0);
    chk("idle_reqcyc", 64'(bus_reqcyc), 64'd0);
    bus_respcyc = 0; bus_resp = 0; bus_resptag = 0;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 0, 1, 64'h1000, 0, 0, 0, 0);
    tbl[2] = mk(1, 1, 0, 0, 1, 64'h1000, 1, 0, 0, 0);
    for (int b = 1; b <= 8; b++)
      tbl[2+b] = mk(0, 0, 1, 64'(b * 'h11), 0, 0, 0, 1, 64'(b * 'h11), 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    if_reqcyc = 1; dm_reqcyc = 1; if_req = 64'h1000; if_reqtag = TAG_IF;
    #12;
    chk("rst_bus_reqcyc", 64'(bus_reqcyc), 0);
    chk("rst_reqack", 64'({if_reqack, dm_reqack}), 0);
    chk("rst_respcyc", 64'({if_respcyc, dm_respcyc, bus_respack}), 0);
    if_reqcyc = 0; dm_reqcyc = 0;
    tick(); tick(); reset = 1; tick();

    if_respack = 1;
    foreach (tbl[i]) begin
      if_reqcyc = tbl[i].ic; bus_reqack = tbl[i].ba;
      bus_respcyc = tbl[i].rc; bus_resp = tbl[i].rd; bus_resptag = tbl[i].rd[12:0];
      @(negedge clk);
      chk($sformatf("t%0d_bus_reqcyc", i), 64'(bus_reqcyc), 64'(tbl[i].e_br));
      chk($sformatf("t%0d_bus_req", i), bus_req, tbl[i].e_ba);
      chk($sformatf("t%0d_bus_reqtag", i), 64'(bus_reqtag), tbl[i].e_br ? 64'(TAG_IF) : 64'd0);
      chk($sformatf("t%0d_if_reqack", i), 64'(if_reqack), 64'(tbl[i].e_ia));
      chk($sformatf("t%0d_if_respcyc", i), 64'(if_respcyc), 64'(tbl[i].e_irc));
      chk($sformatf("t%0d_if_resp", i), if_resp, tbl[i].e_ir);
      chk($sformatf("t%0d_dm_out", i), 64'({dm_reqack, dm_respcyc}) | dm_resp, 64'd0);
      chk($sformatf("t%0d_bus_respack", i), 64'(bus_respack), 64'(tbl[i].e_bra));
      @(posedge clk); #1;
    end
    bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0;

    // Contention with both requesters held
    if_req = 64'h2000; if_reqtag = TAG_IF; if_reqcyc = 1;
    dm_req = 64'h3000; dm_reqtag = TAG_DM; dm_reqcyc = 1;
`ifdef SYSBUS_ARB_RR_EN
    serve(0, 64'h2000, TAG_IF, 0, 0, 1, 0, 0);
    serve(1, 64'h3000, TAG_DM, 0, 0, 1, 0, 0);
    serve(0, 64'h2000, TAG_IF, 0, 0, 1, 0, 0);
`else
    serve(1, 64'h3000, TAG_DM, 0, 0, 1, 0, 0);
    serve(1, 64'h3000, TAG_DM, 0, 0, 1, 0, 0);
    serve(1, 64'h3000, TAG_DM, 0, 0, 1, 0, 0);
`endif
    if_reqcyc = 0; dm_reqcyc = 0;
    tick();

    // Backpressure on beat 4
    if_req = 64'h4000; if_reqcyc = 1;
    serve(0, 64'h4000, TAG_IF, 0, 0, 0, 4, 0);

    // Delayed ack, requester drops reqcyc early
    dm_req = 64'h6000; dm_reqtag = TAG_DM; dm_reqcyc = 1;
    serve(1, 64'h6000, TAG_DM, 5, 1, 0, 0, 0);

    // DM arrives mid IF burst: its request reaches the bus two cycles after IF's last beat
    if_req = 64'h8000; if_reqcyc = 1;
    serve(0, 64'h8000, TAG_IF, 0, 0, 0, 0, 4);
    tick();
    chk("mid_dm_reqcyc", 64'(bus_reqcyc), 64'd1);
    chk("mid_dm_req", bus_req, 64'h5000);
    serve(1, 64'h5000, TAG_DM, 1, 0, 0, 0, 0);
    tick();

    // Async reset at beat 5 of a DM burst
    dm_req = 64'h7000; dm_reqcyc = 1;
    begin
      int n = 0;
      while (!bus_reqcyc && n < 20) begin tick(); n++; end
      chk("rst_seq_grant", 64'(bus_reqcyc), 64'd1);
    end
    bus_reqack = 1; tick(); bus_reqack = 0; dm_reqcyc = 0; dm_respack = 1;
    for (int b = 1; b <= 4; b++) begin
      bus_respcyc = 1; bus_resp = 64'(b * 'h11); tick();
    end
    bus_resp = 64'h55; #1;
    chk("pre_rst_dm_respcyc", 64'(dm_respcyc), 64'd1);
    #2 reset = 0; #1;
    chk("async_rst_dm_respcyc", 64'(dm_respcyc), 64'd0);
    chk("async_rst_dm_resp", dm_resp, 64'd0);
    chk("async_rst_bus_respack", 64'(bus_respack), 64'd0);
    chk("async_rst_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
    bus_respcyc = 0; bus_resp = 0;
    tick(); tick(); reset = 1;
    if_req = 64'h9000; if_reqcyc = 1; tick();
    chk("post_rst_reqcyc", 64'(bus_reqcyc), 64'd1);
    chk("post_rst_req", bus_req, 64'h9000);
    serve(0, 64'h9000, TAG_IF, 0, 0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

- Shares the single Sysbus master port between two requesters: the instruction-fetch FSM (`if_` port) and the load/store unit (`dm_` port).
- Grants one whole read transaction at a time: request phase, then a burst of `BEATS` response beats.
- Forwards acks and response beats to the granted requester only.
- Sits between the core's fetch/memory stages and the top-level `bus_*` ports.

## Interface
- `BUS_DATA_WIDTH`, 64, width of request address and response data
- `BUS_TAG_WIDTH`, 13, width of request/response tags
- `BEATS`, 8, response beats per transaction (64-byte line)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_reqcyc`, `dm_reqcyc`  in  1  requester wants a transaction; held until its `_reqack`
- `if_req`, `dm_req`  in  BUS_DATA_WIDTH  request address
- `if_reqtag`, `dm_reqtag`  in  BUS_TAG_WIDTH  request tag
- `if_reqack`, `dm_reqack`  out  1  one-cycle pulse: bus accepted this requester's request
- `if_respcyc`, `dm_respcyc`  out  1  response beat valid for this requester
- `if_resp`, `dm_resp`  out  BUS_DATA_WIDTH  response data
- `if_resptag`, `dm_resptag`  out  BUS_TAG_WIDTH  response tag
- `if_respack`, `dm_respack`  in  1  requester consumed current beat
- `bus_reqcyc`, `bus_req`, `bus_reqtag`  out  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  to Sysbus
- `bus_reqack`  in  1  Sysbus accepted request
- `bus_respcyc`, `bus_resp`, `bus_resptag`  in  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  from Sysbus
- `bus_respack`  out  1  to Sysbus, beat consumed

## Operation
- States: IDLE, REQ, RESP. Registers:
  - `owner` (IF/DM)
  - captured `addr`/`tag`
  - beat counter, `$clog2(BEATS)+1` bits
  - round-robin pointer `last` (which requester was served last)
- IDLE:
  - No `reqcyc` asserted: stay in IDLE.
  - Otherwise pick a winner, capture its `_req`/`_reqtag` into `addr`/`tag`, set `owner`, clear the counter, go to REQ.
- Arbitration when both requesters are asserted: see Configuration. A single asserted requester always wins.
- REQ:
  - `bus_reqcyc=1`, `bus_req=addr`, `bus_reqtag=tag`.
  - On `bus_reqack`: the owner's `_reqack` is 1 in the same cycle (combinational), go to RESP.
  - Otherwise stay in REQ with the outputs held.
- The captured request is issued even if the owner drops `reqcyc` before the ack.
- RESP:
  - Owner's `_respcyc=bus_respcyc`, `_resp=bus_resp`, `_resptag=bus_resptag`.
  - `bus_respack` = owner's `_respack`.
  - Non-owner sees `_respcyc=0`, and its `_respack` is ignored.
- Beat counting in RESP:
  - A beat completes when `bus_respcyc && bus_respack`; the counter increments.
  - On the completion of beat `BEATS`: set `last=owner`, go to IDLE.
- Non-owner outputs are always `_reqack=0`, `_respcyc=0`, `_resp=0`, `_resptag=0`.
- Bus outputs are 0 outside REQ (`bus_reqcyc`, `bus_req`, `bus_reqtag`) and outside RESP (`bus_respack`).
- Reset mid-transaction: the in-flight transaction is abandoned, with no completion to either requester. The Sysbus is reset by the same reset.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE, `owner`=IF, `last`=DM (so IF wins first), counter=0, captured addr/tag=0.
  - Every output is 0.
- Grant latency: `reqcyc` rising in IDLE at cycle N gives `bus_reqcyc=1` at cycle N+1.
- `_reqack` and `_respcyc`/`bus_respack` are pure combinational passthroughs: zero added latency.
- A beat with `bus_respcyc=1` but owner `_respack=0` is not counted; the bus holds it.
- After the final beat the arbiter is in IDLE at the next cycle.
  - A pending request is granted in that IDLE cycle and reaches `bus_reqcyc` one cycle later.
  - Minimum gap between transactions: 1 idle cycle on `bus_reqcyc`.
- A new request arriving during REQ/RESP waits; it is never dropped.

## Configuration
- Macro `SYSBUS_ARB_RR_EN`.
- Defined: round-robin. On a tie, the requester other than `last` wins, so consecutive transactions alternate under continuous contention.
- Undefined: fixed priority. DM always wins a tie; `last` still updates but is unused. IF may starve under continuous DM traffic; this is accepted.

## Test plan
- Single IF request, addr `0x1000`, tag `{1'b1,SYSBUS_MEMORY,8'b0}`:
  - `bus_reqcyc` the cycle after `if_reqcyc`.
  - `if_reqack` pulses with `bus_reqack`.
  - 8 beats `0x11..0x88` appear on `if_resp`; `dm_respcyc` stays 0.
  - Return to IDLE.
- Simultaneous IF (`0x2000`) and DM (`0x3000`), both held:
  - With RR: `bus_req` order `0x2000`, `0x3000`, `0x2000`…
  - Without RR: `0x3000` repeatedly while DM stays asserted.
- Backpressure: owner `_respack` held low 3 cycles on beat 4 → `bus_respack=0`, counter stays 3, and all 8 beats are still delivered exactly once.
- `bus_reqack` delayed 5 cycles:
  - `bus_req`/`bus_reqtag` are stable throughout.
  - Owner drops `reqcyc` after cycle 2 → request is still issued and completes.
- Reset asserted low at beat 5 of a DM burst → all outputs 0 immediately (async). After release, the state is IDLE and a fresh IF request is granted normally.
- DM request arrives mid-IF burst → DM `bus_reqcyc` appears exactly 2 cycles after IF's 8th beat completes.
